// File: rtl/mem_sram_ctrl.sv
// MEM-stage load/store engine driving an asynchronous 32-bit SRAM.
// It stalls the pipeline for the length of each access and formats load data for write-back.
module mem_sram_ctrl #(
    parameter int ADDR_W      = 20,
    parameter int READ_WAIT   = 1,
    parameter int WRITE_PULSE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        aluop_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       reg2_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [31:0]       wdata_i,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o,
    output logic              stallreq,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i,
    output logic [3:0]        ram_be_n_o,
    output logic              ram_ce_n_o,
    output logic              ram_oe_n_o,
    output logic              ram_we_n_o
);

    // state    | meaning
    // IDLE     | no access in flight; a memory op on the inputs starts one
    // READ     | ce/oe asserted, counting down READ_WAIT, then capture data
    // WR_SETUP | address/data/ce settled, we about to assert
    // WR_PULSE | we held low for WRITE_PULSE cycles
    // WR_HOLD  | we released, ce/be still held for hold time
    // DONE     | access finished; pipeline advances, same op must not restart
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_READ     = 3'd1;
    localparam logic [2:0] S_WR_SETUP = 3'd2;
    localparam logic [2:0] S_WR_PULSE = 3'd3;
    localparam logic [2:0] S_WR_HOLD  = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam logic [7:0] OP_LB = 8'b11100000;
    localparam logic [7:0] OP_LW = 8'b11100011;
    localparam logic [7:0] OP_SB = 8'b11101000;
    localparam logic [7:0] OP_SW = 8'b11101011;

    logic [2:0]  state;
    logic [3:0]  cnt;
    logic [31:0] rdata_q;

    logic        is_load;
    logic        is_store;
    logic        is_byte;
    logic [1:0]  lane;
    logic [3:0]  lane_be_n;
    logic [31:0] store_data;
    logic [7:0]  lb_byte;
    logic [31:0] load_fmt;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr_i[31:ADDR_W+2]};

    assign is_load    = (aluop_i == OP_LB) || (aluop_i == OP_LW);
    assign is_store   = (aluop_i == OP_SB) || (aluop_i == OP_SW);
    assign is_byte    = (aluop_i == OP_LB) || (aluop_i == OP_SB);
    assign lane       = mem_addr_i[1:0];
    assign lane_be_n  = is_byte ? ~(4'b0001 << lane) : 4'b0000;
    assign store_data = (aluop_i == OP_SB) ? {4{reg2_i[7:0]}} : reg2_i;

    always_comb begin
        lb_byte = rdata_q[7:0];
        case (lane)
            2'd0: lb_byte = rdata_q[7:0];
            2'd1: lb_byte = rdata_q[15:8];
            2'd2: lb_byte = rdata_q[23:16];
            2'd3: lb_byte = rdata_q[31:24];
            default: lb_byte = rdata_q[7:0];
        endcase
    end

    assign load_fmt = (aluop_i == OP_LB) ? {{24{lb_byte[7]}}, lb_byte} : rdata_q;

    always_comb begin
        stallreq = 1'b0;
        if (!rst) begin
            case (state)
                S_IDLE:                               stallreq = is_load || is_store;
                S_READ, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD: stallreq = 1'b1;
                default:                              stallreq = 1'b0;
            endcase
        end
    end

    always_comb begin
        wd_o    = wd_i;
        wreg_o  = wreg_i;
        wdata_o = is_load ? load_fmt : wdata_i;
        if (rst) begin
            wd_o    = 5'd0;
            wreg_o  = 1'b0;
            wdata_o = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            ram_ce_n_o  <= 1'b1;
            ram_oe_n_o  <= 1'b1;
            ram_we_n_o  <= 1'b1;
            ram_be_n_o  <= 4'b1111;
            ram_addr_o  <= '0;
            ram_wdata_o <= 32'd0;
            rdata_q     <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_load) begin
                        state      <= S_READ;
                        cnt        <= 4'(READ_WAIT);
                        ram_ce_n_o <= 1'b0;
                        ram_oe_n_o <= 1'b0;
                        ram_we_n_o <= 1'b1;
                        ram_addr_o <= mem_addr_i[ADDR_W+1:2];
                        ram_be_n_o <= lane_be_n;
                    end else if (is_store) begin
                        state       <= S_WR_SETUP;
                        ram_ce_n_o  <= 1'b0;
                        ram_oe_n_o  <= 1'b1;
                        ram_we_n_o  <= 1'b1;
                        ram_addr_o  <= mem_addr_i[ADDR_W+1:2];
                        ram_wdata_o <= store_data;
                        ram_be_n_o  <= lane_be_n;
                    end else begin
                        ram_ce_n_o <= 1'b1;
                        ram_oe_n_o <= 1'b1;
                        ram_we_n_o <= 1'b1;
                        ram_be_n_o <= 4'b1111;
                    end
                end
                S_READ: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rdata_q    <= ram_rdata_i;
                        ram_ce_n_o <= 1'b1;
                        ram_oe_n_o <= 1'b1;
                        ram_be_n_o <= 4'b1111;
                        state      <= S_DONE;
                    end
                end
                S_WR_SETUP: begin
                    ram_we_n_o <= 1'b0;
                    cnt        <= 4'(WRITE_PULSE - 1);
                    state      <= S_WR_PULSE;
                end
                S_WR_PULSE: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        ram_we_n_o <= 1'b1;
                        state      <= S_WR_HOLD;
                    end
                end
                S_WR_HOLD: begin
                    ram_ce_n_o <= 1'b1;
                    ram_be_n_o <= 4'b1111;
                    state      <= S_DONE;
                end
                // Inputs still carry the finished op here, so never re-decode them.
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Self-checking bench for mem_sram_ctrl: a cycle-offset model of the SRAM pin waveform
// per transaction, a small SRAM array, and literal expectations for key cases.
module tb_mem_sram_ctrl;
    localparam int ADDR_W = 20;
    localparam int RW     = 1;
    localparam int WP     = 1;

    localparam logic [7:0] LB = 8'b11100000;
    localparam logic [7:0] LW = 8'b11100011;
    localparam logic [7:0] SB = 8'b11101000;
    localparam logic [7:0] SW = 8'b11101011;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        aluop_i;
    logic [31:0]       mem_addr_i;
    logic [31:0]       reg2_i;
    logic [4:0]        wd_i;
    logic              wreg_i;
    logic [31:0]       wdata_i;
    logic [4:0]        wd_o;
    logic              wreg_o;
    logic [31:0]       wdata_o;
    logic              stallreq;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [31:0]       ram_wdata_o;
    logic [31:0]       ram_rdata_i;
    logic [3:0]        ram_be_n_o;
    logic              ram_ce_n_o;
    logic              ram_oe_n_o;
    logic              ram_we_n_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [64];
    logic        pre_en = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;

    mem_sram_ctrl #(.ADDR_W(ADDR_W), .READ_WAIT(RW), .WRITE_PULSE(WP)) dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .wd_o(wd_o), .wreg_o(wreg_o),
        .wdata_o(wdata_o), .stallreq(stallreq), .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .ram_be_n_o(ram_be_n_o),
        .ram_ce_n_o(ram_ce_n_o), .ram_oe_n_o(ram_oe_n_o), .ram_we_n_o(ram_we_n_o)
    );

    always #5 clk = ~clk;

    assign ram_rdata_i = mem[ram_addr_o[5:0]];

    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_idx] <= pre_val;
        end else if (!ram_we_n_o && !ram_ce_n_o) begin
            for (int b = 0; b < 4; b++)
                if (!ram_be_n_o[b]) mem[ram_addr_o[5:0]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lb_fmt(input logic [31:0] word, input int k);
        logic [7:0] b;
        b = 8'(word >> (8 * k));
        return {{24{b[7]}}, b};
    endfunction

    task automatic preload(input int idx, input logic [31:0] val);
        pre_en  = 1'b1;
        pre_idx = 6'(idx);
        pre_val = val;
        @(posedge clk); #1;
        pre_en  = 1'b0;
    endtask

    // Present one instruction and check every cycle from issue through the DONE cycle.
    task automatic do_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] alu, input logic [4:0] wd, input logic wr,
                         input logic [31:0] exp_wb);
        bit ld, st, byt;
        int L, k_lane;
        logic [3:0]  mask;
        logic [31:0] sdata;
        logic        ce_e, oe_e, we_e;
        aluop_i = op; mem_addr_i = addr; reg2_i = data; wdata_i = alu; wd_i = wd; wreg_i = wr;
        ld = (op == LB) || (op == LW);
        st = (op == SB) || (op == SW);
        byt = (op == LB) || (op == SB);
        k_lane = int'(addr[1:0]);
        mask  = byt ? ~(4'b0001 << k_lane) : 4'b0000;
        sdata = (op == SB) ? {4{data[7:0]}} : data;
        L = ld ? RW + 2 : (st ? WP + 3 : 0);
        for (int k = 0; k <= L; k++) begin
            @(negedge clk);
            ce_e = 1'b1; oe_e = 1'b1; we_e = 1'b1;
            if (ld && k >= 1 && k <= RW + 1) begin ce_e = 1'b0; oe_e = 1'b0; end
            if (st && k >= 1 && k <= WP + 2) ce_e = 1'b0;
            if (st && k >= 2 && k <= WP + 1) we_e = 1'b0;
            chk("stallreq", 32'(stallreq), 32'(k < L));
            chk("wd_o", 32'(wd_o), 32'(wd));
            chk("wreg_o", 32'(wreg_o), 32'(wr));
            chk("ce_n", 32'(ram_ce_n_o), 32'(ce_e));
            chk("oe_n", 32'(ram_oe_n_o), 32'(oe_e));
            chk("we_n", 32'(ram_we_n_o), 32'(we_e));
            chk("be_n", 32'(ram_be_n_o), 32'(ce_e ? 4'b1111 : mask));
            if ((ld || st) && k >= 1) chk("ram_addr", 32'(ram_addr_o), 32'(addr[ADDR_W+1:2]));
            if (st && k >= 1 && k <= WP + 2) chk("ram_wdata", ram_wdata_o, sdata);
            if (!ld || k == L) chk("wdata_o", wdata_o, ld ? exp_wb : alu);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        aluop_i = LW; mem_addr_i = 32'h10; reg2_i = 32'h1; wd_i = 5'd7; wreg_i = 1'b1;
        wdata_i = 32'hCAFE_0001;
        #1;
        chk("rst_stall", 32'(stallreq), 32'd0);
        chk("rst_wdata_o", wdata_o, 32'd0);
        chk("rst_wreg_o", 32'(wreg_o), 32'd0);
        chk("rst_wd_o", 32'(wd_o), 32'd0);
        preload(2, 32'h0080_7F00);
        preload(4, 32'h0);
        @(posedge clk); #1;
        chk("rst_ce_n", 32'(ram_ce_n_o), 32'd1);
        chk("rst_oe_n", 32'(ram_oe_n_o), 32'd1);
        chk("rst_we_n", 32'(ram_we_n_o), 32'd1);
        chk("rst_be_n", 32'(ram_be_n_o), 32'hF);
        chk("rst_addr", 32'(ram_addr_o), 32'd0);
        chk("rst_wdata", ram_wdata_o, 32'd0);
        rst = 1'b0;

        do_op(8'h25, 32'h44, 32'h9, 32'h1234, 5'd3, 1'b1, 32'h0);
        do_op(SW, 32'h0000_0010, 32'hDEAD_BEEF, 32'h10, 5'd0, 1'b0, 32'h0);
        chk("mem_after_sw", mem[4], 32'hDEAD_BEEF);
        do_op(SB, 32'h0000_0013, 32'h0000_00A5, 32'h13, 5'd0, 1'b0, 32'h0);
        chk("mem_after_sb", mem[4], 32'hA5AD_BEEF);
        do_op(LB, 32'h0000_000A, 32'h0, 32'h5555, 5'd9, 1'b1, 32'hFFFF_FF80);
        do_op(LB, 32'h0000_0009, 32'h0, 32'h5555, 5'd10, 1'b1, 32'h0000_007F);
        do_op(LB, 32'h0000_0013, 32'h0, 32'h5555, 5'd11, 1'b1, lb_fmt(mem[4], 3));
        // back-to-back: LW then SW with no bubble beyond the DONE cycle
        do_op(LW, 32'h0000_0011, 32'h0, 32'h7777, 5'd12, 1'b1, 32'hA5AD_BEEF);
        do_op(SW, 32'h0000_0020, 32'h1122_3344, 32'h20, 5'd0, 1'b0, 32'h0);
        do_op(LW, 32'h0000_0020, 32'h0, 32'h0, 5'd13, 1'b1, 32'h1122_3344);
        do_op(8'h21, 32'h0, 32'h0, 32'hABCD_0000, 5'd14, 1'b0, 32'h0);

        // reset during the write pulse
        aluop_i = SW; mem_addr_i = 32'h30; reg2_i = 32'h55; wdata_i = 32'h1; wd_i = 5'd1; wreg_i = 1'b1;
        @(negedge clk);
        chk("mid_stall0", 32'(stallreq), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_we_low", 32'(ram_we_n_o), 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_stall", 32'(stallreq), 32'd0);
        chk("mid_rst_wdata_o", wdata_o, 32'd0);
        chk("mid_rst_wreg_o", 32'(wreg_o), 32'd0);
        @(posedge clk); #1;
        chk("mid_rst_we_n", 32'(ram_we_n_o), 32'd1);
        chk("mid_rst_ce_n", 32'(ram_ce_n_o), 32'd1);
        chk("mid_rst_be_n", 32'(ram_be_n_o), 32'hF);
        chk("mid_rst_addr", 32'(ram_addr_o), 32'd0);
        rst = 1'b0;
        aluop_i = 8'h25;
        @(negedge clk);
        chk("post_rst_stall", 32'(stallreq), 32'd0);
        chk("post_rst_ce_n", 32'(ram_ce_n_o), 32'd1);
        @(posedge clk); #1;
        do_op(LW, 32'h0000_0008, 32'h0, 32'h0, 5'd15, 1'b1, 32'h0080_7F00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_sram_ctrl.md
Name: mem_sram_ctrl

Overview:
- MEM-stage load/store engine. Consumes the memory-access opcode, effective address and store data produced by the execute stage (via the EX/MEM register) and drives one asynchronous 32-bit SRAM with a multi-cycle handshake.
- Stalls the pipeline until the access completes, then formats load data for write-back.
- Non-memory instructions pass through untouched with zero added latency.

Parameters:
- ADDR_W, 20, SRAM word-address width; ram_addr_o = mem_addr_i[ADDR_W+1:2]
- READ_WAIT, 1, extra cycles oe held before capture (0..15)
- WRITE_PULSE, 1, cycles we_n held low (1..15)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- aluop_i  in  8  op from EX: LB=8'b11100000, LW=8'b11100011, SB=8'b11101000, SW=8'b11101011; all others are non-memory
- mem_addr_i  in  32  effective byte address
- reg2_i  in  32  store data
- wd_i  in  5  destination register
- wreg_i  in  1  write enable
- wdata_i  in  32  ALU result
- wd_o  out  5  to MEM/WB
- wreg_o  out  1  to MEM/WB
- wdata_o  out  32  to MEM/WB
- stallreq  out  1  hold pipeline (combinational)
- ram_addr_o  out  ADDR_W  SRAM word address (registered)
- ram_wdata_o  out  32  SRAM write data (registered)
- ram_rdata_i  in  32  SRAM read data
- ram_be_n_o  out  4  byte enables, active-low (registered)
- ram_ce_n_o, ram_oe_n_o, ram_we_n_o  out  1 each  active-low strobes (registered)

Behaviour:
- States: IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD, DONE. Counter cnt is 4-bit.
- IDLE:
  - Load op: next state READ, cnt=READ_WAIT; registers ce_n=0, oe_n=0, we_n=1, addr, be_n.
  - Store op: next state WR_SETUP; registers ce_n=0, oe_n=1, we_n=1, addr, data, be_n.
  - Otherwise stay in IDLE; strobes high, be_n=4'b1111.
- READ:
  - cnt!=0: decrement.
  - cnt==0: capture ram_rdata_i into rdata_q, deassert ce_n/oe_n, go DONE.
- WR_SETUP: we_n=0, cnt=WRITE_PULSE-1, go WR_PULSE.
- WR_PULSE: hold we_n=0 until cnt==0; then we_n=1 and go WR_HOLD. Address and data stay stable.
- WR_HOLD: ce_n=1, be_n=1111, go DONE.
- DONE: always go IDLE. The same instruction is still on the inputs this cycle, and it must not restart.
- stallreq = !rst && ((IDLE && mem op) || READ || WR_SETUP || WR_PULSE || WR_HOLD). It is 0 in DONE, which lets the pipeline advance exactly once.
- Latency (cycles stallreq high):
  - load = READ_WAIT+2
  - store = WRITE_PULSE+3
- Byte lanes, little-endian: lane k = bits [8k+7:8k], k = mem_addr_i[1:0].
  - LW/SW: be_n=4'b0000; addr[1:0] ignored (forced word-aligned).
  - SB: be_n = ~(4'b0001<<k); wdata = {4{reg2_i[7:0]}}.
  - LB: wdata_o = sign-extended lane k of rdata_q.
- Write-back outputs, combinational:
  - wd_o=wd_i, wreg_o=wreg_i.
  - wdata_o = formatted rdata_q for LB/LW; otherwise wdata_i.
  - Stores pass wreg_i unchanged; decode clears it.
- Reset (any state, including mid-access): state=IDLE, cnt=0, ce_n=oe_n=we_n=1, be_n=4'b1111, addr=0, ram_wdata=0, rdata_q=0. While rst=1: wd_o=0, wreg_o=0, wdata_o=0, stallreq=0.
- Back-to-back memory ops: the second op starts from IDLE on the cycle after DONE. There are no idle bubbles beyond that cycle.

Test Plan:
- Non-memory op, aluop=8'h25, wdata_i=32'h1234 -> same-cycle wdata_o=32'h1234; stallreq=0; strobes high.
- SW addr=32'h0000_0010, data=32'hDEADBEEF (WRITE_PULSE=1) -> ram_addr=4, be_n=0000; we_n low exactly 1 cycle with data stable around it; stallreq high 4 cycles, then DONE.
- SB addr=32'h0000_0013, reg2=32'h0000_00A5 -> be_n=4'b0111, ram_wdata=32'hA5A5A5A5.
- LB addr=...2, SRAM word 32'h0080_7F00 -> wdata_o=32'hFFFF_FF80. Same with addr=...1 -> 32'h0000_007F. Stall lasts READ_WAIT+2 cycles.
- LW followed immediately by SW -> no re-issue of the LW in DONE; SW strobes start the cycle after DONE.
- rst asserted during WR_PULSE -> next edge we_n=1, ce_n=1, be_n=1111, stallreq=0, state IDLE; a subsequent LW completes normally.
